ahb_slave_arbiter: RTL and testbench

Per-slave arbiter that sits in front of the slave-side payload mux.
- Decides which master owns the slave port and produces the one-hot address-phase select for that mux.
- Produces a delayed one-hot data-phase select for the write-data and response path.
- Arbitration is round-robin. Fixed-length bursts and locked sequences are never split.

---
 rtl/ahb_slave_arbiter.sv | 223 ++++++++++++++++++++++
 tb/tb_ahb_slave_arbiter.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_slave_arbiter.sv
// -----------------------------------------------------------------------------
// ahb_slave_arbiter
//
// Per-slave arbiter placed in front of the slave-side payload mux. It decides
// which master owns the slave port (round-robin), keeps fixed-length bursts and
// locked sequences together, and produces the one-hot select vectors used by
// the address-phase mux and the data-phase (write data / response) mux.
//
// Ports:
//   hclk        - clock, all state changes on the rising edge
//   hreset      - synchronous, active-high reset
//   hbusreq     - per-master request for this slave
//   hlock       - per-master locked-transfer indication
//   htrans_in   - per-master HTRANS, master i in bits [2*i+1:2*i]
//   hburst_in   - per-master HBURST, master i in bits [3*i+2:3*i]
//   hready      - slave HREADYOUT; 1 = current data phase completes this cycle
//   hgrant      - one-hot grant to the masters, all zero = no owner
//   sel_addr    - one-hot address-phase select, identical to hgrant
//   sel_data    - one-hot data-phase select, sel_addr delayed by one data phase
//   hmaster_id  - binary index of the current owner, 0 when there is no owner
// -----------------------------------------------------------------------------
module ahb_slave_arbiter #(
   parameter int CHANNEL_NUM = 3,
   parameter int ID_W        = (CHANNEL_NUM > 1) ? $clog2(CHANNEL_NUM) : 1
) (
   input  logic                     hclk,
   input  logic                     hreset,
   input  logic [CHANNEL_NUM-1:0]   hbusreq,
   input  logic [CHANNEL_NUM-1:0]   hlock,
   input  logic [2*CHANNEL_NUM-1:0] htrans_in,
   input  logic [3*CHANNEL_NUM-1:0] hburst_in,
   input  logic                     hready,
   output logic [CHANNEL_NUM-1:0]   hgrant,
   output logic [CHANNEL_NUM-1:0]   sel_addr,
   output logic [CHANNEL_NUM-1:0]   sel_data,
   output logic [ID_W-1:0]          hmaster_id
);

   localparam logic [1:0] TRANS_IDLE   = 2'b00;
   localparam logic [1:0] TRANS_NONSEQ = 2'b10;
   localparam logic [1:0] TRANS_SEQ    = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_OWN    = 2'd1,
      ST_LOCKED = 2'd2
   } state_t;

   // Beats in a burst; 0 means INCR (unbounded, ends only on IDLE or a
   // dropped request).
   function automatic logic [4:0] burst_len(input logic [2:0] burst);
      case (burst)
         3'b000:          burst_len = 5'd1;
         3'b001:          burst_len = 5'd0;
         3'b010, 3'b011:  burst_len = 5'd4;
         3'b100, 3'b101:  burst_len = 5'd8;
         default:         burst_len = 5'd16;
      endcase
   endfunction

   // ---------------------------------------------------------------- state
   state_t                   state_q,    state_d;
   logic [CHANNEL_NUM-1:0]   grant_q,    grant_d;
   logic [CHANNEL_NUM-1:0]   sel_data_q, sel_data_d;
   logic [ID_W-1:0]          owner_q,    owner_d;
   logic [ID_W-1:0]          rr_ptr_q,   rr_ptr_d;
   logic [4:0]               count_q,    count_d;
   logic [4:0]               len_q,      len_d;

   // ------------------------------------------------- owner's bus signals
   logic [1:0] owner_trans;
   logic [2:0] owner_burst;
   logic       owner_req;
   logic       owner_lock;

   // NOTE: every signal assigned in an always_comb gets a default at the top
   // of the block, so no path can leave it unassigned and infer a latch.
   always_comb begin
      owner_trans = TRANS_IDLE;
      owner_burst = 3'b000;
      owner_req   = 1'b0;
      owner_lock  = 1'b0;
      for (int i = 0; i < CHANNEL_NUM; i++) begin
         if (owner_q == ID_W'(i)) begin
            owner_trans = htrans_in[2*i +: 2];
            owner_burst = hburst_in[3*i +: 3];
            owner_req   = hbusreq[i];
            owner_lock  = hlock[i];
         end
      end
   end

   // ------------------------------------------------ round-robin search
   // First pass looks at channels at or above the pointer, second pass wraps
   // to the channels below it. The owner sits just below the pointer, so it
   // is only chosen again when nobody else is requesting.
   logic            found;
   logic [ID_W-1:0] winner;

   always_comb begin
      found  = 1'b0;
      winner = '0;
      for (int i = 0; i < CHANNEL_NUM; i++) begin
         if (!found && hbusreq[i] && (i >= int'(rr_ptr_q))) begin
            found  = 1'b1;
            winner = ID_W'(i);
         end
      end
      for (int i = 0; i < CHANNEL_NUM; i++) begin
         if (!found && hbusreq[i]) begin
            found  = 1'b1;
            winner = ID_W'(i);
         end
      end
   end

   // ------------------------------------------------- arbitration point
   // count_q holds the beats already completed before this cycle and lags the
   // bus by one cycle, so the last beat of a fixed burst is recognised either
   // after it completed (count == len) or while it is on the bus as a SEQ
   // (count == len-1). A burst's first (NONSEQ) cycle is never an end point.
   logic burst_end;
   logic mid_burst;
   logic rearb;

   always_comb begin
      burst_end = (len_q != 5'd0) &&
                  ((count_q == len_q) ||
                   ((count_q == len_q - 5'd1) && (owner_trans == TRANS_SEQ)));
      mid_burst = (len_q != 5'd0) && !burst_end;
      rearb     = 1'b0;
      if (hready) begin
         case (state_q)
            ST_IDLE:   rearb = 1'b1;
            ST_OWN:    rearb = !owner_lock && !mid_burst &&
                               ((owner_trans == TRANS_IDLE) || !owner_req ||
                                burst_end);
            // A locked sequence is released only by an IDLE with hlock low.
            ST_LOCKED: rearb = !owner_lock && (owner_trans == TRANS_IDLE);
            default:   rearb = 1'b0;
         endcase
      end
   end

   // ------------------------------------------------------ next state
   always_comb begin
      state_d    = state_q;
      grant_d    = grant_q;
      owner_d    = owner_q;
      rr_ptr_d   = rr_ptr_q;
      count_d    = count_q;
      len_d      = len_q;
      sel_data_d = sel_data_q;

      if (hready) begin
         // The data phase that starts now belongs to the current address owner.
         sel_data_d = grant_q;

         if (state_q != ST_IDLE) begin
            if (owner_trans == TRANS_NONSEQ) begin
               count_d = 5'd1;
               len_d   = burst_len(owner_burst);
            end else if (owner_trans == TRANS_SEQ) begin
               count_d = count_q + 5'd1;
            end
         end

         if (rearb) begin
            // A new tenure always starts with a clean beat count.
            count_d = 5'd0;
            len_d   = 5'd0;
            if (found) begin
               state_d = ST_OWN;
               owner_d = winner;
               for (int i = 0; i < CHANNEL_NUM; i++) begin
                  grant_d[i] = (winner == ID_W'(i));
               end
               if (winner == ID_W'(CHANNEL_NUM - 1)) begin
                  rr_ptr_d = '0;
               end else begin
                  rr_ptr_d = winner + 1'b1;
               end
            end else begin
               state_d = ST_IDLE;
               owner_d = '0;
               grant_d = '0;
            end
         end else if ((state_q == ST_OWN) && owner_lock &&
                      (owner_trans == TRANS_NONSEQ)) begin
            state_d = ST_LOCKED;
         end
      end
   end

   // ------------------------------------------------------------ flops
   // NOTE: sequential state is only ever written with non-blocking (<=)
   // assignments, so every flop samples the values from before the edge.
   always_ff @(posedge hclk) begin
      if (hreset) begin
         state_q    <= ST_IDLE;
         grant_q    <= '0;
         sel_data_q <= '0;
         owner_q    <= '0;
         rr_ptr_q   <= '0;
         count_q    <= 5'd0;
         len_q      <= 5'd0;
      end else begin
         state_q    <= state_d;
         grant_q    <= grant_d;
         sel_data_q <= sel_data_d;
         owner_q    <= owner_d;
         rr_ptr_q   <= rr_ptr_d;
         count_q    <= count_d;
         len_q      <= len_d;
      end
   end

   assign hgrant     = grant_q;
   assign sel_addr   = grant_q;
   assign sel_data   = sel_data_q;
   assign hmaster_id = owner_q;

endmodule

// File: tb/tb_ahb_slave_arbiter.sv
// -----------------------------------------------------------------------------
// tb_ahb_slave_arbiter
//
// Scripted bench for ahb_slave_arbiter with three masters. Each step drives the
// inputs for one cycle and queues the outputs expected after the next rising
// edge; the scenario task then pops that entry and compares it against
// {hgrant, sel_addr, sel_data, hmaster_id} sampled 1 ns after the edge.
// Only the owning master's HTRANS/HBURST slot carries traffic, the others
// drive IDLE.
// -----------------------------------------------------------------------------
module tb_ahb_slave_arbiter;

   localparam int N = 3;

   localparam logic [1:0] T_IDLE   = 2'b00;
   localparam logic [1:0] T_NONSEQ = 2'b10;
   localparam logic [1:0] T_SEQ    = 2'b11;

   localparam logic [2:0] B_SINGLE = 3'b000;
   localparam logic [2:0] B_INCR4  = 3'b011;
   localparam logic [2:0] B_INCR8  = 3'b101;

   logic           hclk = 1'b0;
   logic           hreset;
   logic [N-1:0]   hbusreq;
   logic [N-1:0]   hlock;
   logic [2*N-1:0] htrans_in;
   logic [3*N-1:0] hburst_in;
   logic           hready;
   logic [N-1:0]   hgrant;
   logic [N-1:0]   sel_addr;
   logic [N-1:0]   sel_data;
   logic [1:0]     hmaster_id;

   // Expected {grant, sel_addr, sel_data, id}, pushed when a step is driven.
   logic [10:0] sb[$];
   logic [10:0] obs;
   logic [10:0] exp_w;

   int n_checks = 0;
   int n_err    = 0;

   ahb_slave_arbiter #(.CHANNEL_NUM(N)) dut (
      .hclk       (hclk),
      .hreset     (hreset),
      .hbusreq    (hbusreq),
      .hlock      (hlock),
      .htrans_in  (htrans_in),
      .hburst_in  (hburst_in),
      .hready     (hready),
      .hgrant     (hgrant),
      .sel_addr   (sel_addr),
      .sel_data   (sel_data),
      .hmaster_id (hmaster_id)
   );

   always #5 hclk = ~hclk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at %0t", $time);
      $fatal(1);
   end

   task automatic drive(input logic rst, input logic [2:0] req,
                        input logic [2:0] lock, input int m,
                        input logic [1:0] tr, input logic [2:0] bu,
                        input logic rdy);
      hreset    = rst;
      hbusreq   = req;
      hlock     = lock;
      htrans_in = '0;
      hburst_in = '0;
      htrans_in[2*m +: 2] = tr;
      hburst_in[3*m +: 3] = bu;
      hready    = rdy;
   endtask

   // Drive one cycle, queue what must be visible after the edge, clock it.
   task automatic apply(input logic rst, input logic [2:0] req,
                        input logic [2:0] lock, input int m,
                        input logic [1:0] tr, input logic [2:0] bu,
                        input logic rdy, input logic [2:0] g,
                        input logic [2:0] sd, input logic [1:0] id);
      drive(rst, req, lock, m, tr, bu, rdy);
      sb.push_back({g, g, sd, id});
      @(posedge hclk);
      #1;
   endtask

   task automatic reset_dut();
      drive(1'b1, 3'b000, 3'b000, 0, T_IDLE, B_SINGLE, 1'b1);
      repeat (2) @(posedge hclk);
      #1;
   endtask

   // ------------------------------------------------------------------
   task automatic test_reset();
      for (int k = 0; k < 3; k++) begin
         case (k)
            0: apply(1, 3'b111, 3'b000, 0, T_IDLE, B_SINGLE, 1, 3'b000, 3'b000, 2'd0);
            1: apply(0, 3'b111, 3'b000, 0, T_IDLE, B_SINGLE, 1, 3'b001, 3'b000, 2'd0);
            2: apply(0, 3'b111, 3'b000, 0, T_IDLE, B_SINGLE, 1, 3'b010, 3'b001, 2'd1);
            default: ;
         endcase
         obs   = {hgrant, sel_addr, sel_data, hmaster_id};
         exp_w = sb.pop_front();
         n_checks++;
         if (obs !== exp_w) begin
            n_err++;
            $display("FAIL reset step %0d: {grant,sel_addr,sel_data,id} got %b expected %b",
                     k, obs, exp_w);
         end
      end
   endtask

   // Every tenure of a SINGLE requester lasts two cycles: the NONSEQ cycle and
   // the cycle in which the completed beat is recognised.
   task automatic test_rotation();
      reset_dut();
      for (int k = 0; k < 7; k++) begin
         case (k)
            0: apply(0, 3'b111, 3'b000, 0, T_IDLE,   B_SINGLE, 1, 3'b001, 3'b000, 2'd0);
            1: apply(0, 3'b111, 3'b000, 0, T_NONSEQ, B_SINGLE, 1, 3'b001, 3'b001, 2'd0);
            2: apply(0, 3'b111, 3'b000, 0, T_NONSEQ, B_SINGLE, 1, 3'b010, 3'b001, 2'd1);
            3: apply(0, 3'b111, 3'b000, 1, T_NONSEQ, B_SINGLE, 1, 3'b010, 3'b010, 2'd1);
            4: apply(0, 3'b111, 3'b000, 1, T_NONSEQ, B_SINGLE, 1, 3'b100, 3'b010, 2'd2);
            5: apply(0, 3'b111, 3'b000, 2, T_NONSEQ, B_SINGLE, 1, 3'b100, 3'b100, 2'd2);
            6: apply(0, 3'b111, 3'b000, 2, T_NONSEQ, B_SINGLE, 1, 3'b001, 3'b100, 2'd0);
            default: ;
         endcase
         obs   = {hgrant, sel_addr, sel_data, hmaster_id};
         exp_w = sb.pop_front();
         n_checks++;
         if (obs !== exp_w) begin
            n_err++;
            $display("FAIL rotation step %0d: {grant,sel_addr,sel_data,id} got %b expected %b",
                     k, obs, exp_w);
         end
      end
   endtask

   // Master 1 runs INCR4 and drops its request mid-burst; the burst still
   // keeps the port for all four beats.
   task automatic test_incr4();
      reset_dut();
      for (int k = 0; k < 8; k++) begin
         case (k)
            0: apply(0, 3'b111, 3'b000, 0, T_IDLE,   B_SINGLE, 1, 3'b001, 3'b000, 2'd0);
            1: apply(0, 3'b111, 3'b000, 0, T_NONSEQ, B_SINGLE, 1, 3'b001, 3'b001, 2'd0);
            2: apply(0, 3'b111, 3'b000, 0, T_NONSEQ, B_SINGLE, 1, 3'b010, 3'b001, 2'd1);
            3: apply(0, 3'b111, 3'b000, 1, T_NONSEQ, B_INCR4,  1, 3'b010, 3'b010, 2'd1);
            4: apply(0, 3'b111, 3'b000, 1, T_SEQ,    B_INCR4,  1, 3'b010, 3'b010, 2'd1);
            5: apply(0, 3'b101, 3'b000, 1, T_SEQ,    B_INCR4,  1, 3'b010, 3'b010, 2'd1);
            6: apply(0, 3'b101, 3'b000, 1, T_SEQ,    B_INCR4,  1, 3'b100, 3'b010, 2'd2);
            7: apply(0, 3'b101, 3'b000, 2, T_IDLE,   B_SINGLE, 1, 3'b001, 3'b100, 2'd0);
            default: ;
         endcase
         obs   = {hgrant, sel_addr, sel_data, hmaster_id};
         exp_w = sb.pop_front();
         n_checks++;
         if (obs !== exp_w) begin
            n_err++;
            $display("FAIL incr4 step %0d: {grant,sel_addr,sel_data,id} got %b expected %b",
                     k, obs, exp_w);
         end
      end
   endtask

   // INCR4 stalled for three cycles on beat 2, then a stall right after the
   // handover where sel_data must hold the previous owner.
   task automatic test_wait_states();
      reset_dut();
      for (int k = 0; k < 10; k++) begin
         case (k)
            0: apply(0, 3'b111, 3'b000, 0, T_IDLE,   B_SINGLE, 1, 3'b001, 3'b000, 2'd0);
            1: apply(0, 3'b111, 3'b000, 0, T_NONSEQ, B_INCR4,  1, 3'b001, 3'b001, 2'd0);
            2: apply(0, 3'b111, 3'b000, 0, T_SEQ,    B_INCR4,  0, 3'b001, 3'b001, 2'd0);
            3: apply(0, 3'b111, 3'b000, 0, T_SEQ,    B_INCR4,  0, 3'b001, 3'b001, 2'd0);
            4: apply(0, 3'b111, 3'b000, 0, T_SEQ,    B_INCR4,  0, 3'b001, 3'b001, 2'd0);
            5: apply(0, 3'b111, 3'b000, 0, T_SEQ,    B_INCR4,  1, 3'b001, 3'b001, 2'd0);
            6: apply(0, 3'b111, 3'b000, 0, T_SEQ,    B_INCR4,  1, 3'b001, 3'b001, 2'd0);
            7: apply(0, 3'b111, 3'b000, 0, T_SEQ,    B_INCR4,  1, 3'b010, 3'b001, 2'd1);
            8: apply(0, 3'b111, 3'b000, 1, T_IDLE,   B_SINGLE, 0, 3'b010, 3'b001, 2'd1);
            9: apply(0, 3'b111, 3'b000, 1, T_IDLE,   B_SINGLE, 1, 3'b100, 3'b010, 2'd2);
            default: ;
         endcase
         obs   = {hgrant, sel_addr, sel_data, hmaster_id};
         exp_w = sb.pop_front();
         n_checks++;
         if (obs !== exp_w) begin
            n_err++;
            $display("FAIL wait step %0d: {grant,sel_addr,sel_data,id} got %b expected %b",
                     k, obs, exp_w);
         end
      end
   endtask

   // Master 0 locks two SINGLE transfers while master 2 waits. Neither a
   // completed beat nor dropping hlock alone releases the port; only an IDLE
   // with hlock low does.
   task automatic test_lock();
      reset_dut();
      for (int k = 0; k < 8; k++) begin
         case (k)
            0: apply(0, 3'b101, 3'b000, 0, T_IDLE,   B_SINGLE, 1, 3'b001, 3'b000, 2'd0);
            1: apply(0, 3'b101, 3'b001, 0, T_NONSEQ, B_SINGLE, 1, 3'b001, 3'b001, 2'd0);
            2: apply(0, 3'b101, 3'b001, 0, T_NONSEQ, B_SINGLE, 1, 3'b001, 3'b001, 2'd0);
            3: apply(0, 3'b101, 3'b001, 0, T_IDLE,   B_SINGLE, 1, 3'b001, 3'b001, 2'd0);
            4: apply(0, 3'b101, 3'b000, 0, T_NONSEQ, B_SINGLE, 1, 3'b001, 3'b001, 2'd0);
            5: apply(0, 3'b101, 3'b000, 0, T_IDLE,   B_SINGLE, 0, 3'b001, 3'b001, 2'd0);
            6: apply(0, 3'b101, 3'b000, 0, T_IDLE,   B_SINGLE, 1, 3'b100, 3'b001, 2'd2);
            7: apply(0, 3'b101, 3'b000, 2, T_IDLE,   B_SINGLE, 1, 3'b001, 3'b100, 2'd0);
            default: ;
         endcase
         obs   = {hgrant, sel_addr, sel_data, hmaster_id};
         exp_w = sb.pop_front();
         n_checks++;
         if (obs !== exp_w) begin
            n_err++;
            $display("FAIL lock step %0d: {grant,sel_addr,sel_data,id} got %b expected %b",
                     k, obs, exp_w);
         end
      end
   endtask

   // Reset on beat 3 of an INCR8: the pointer returns to 0 (master 0 wins over
   // master 2) and no partial beat count survives.
   task automatic test_reset_mid_burst();
      reset_dut();
      for (int k = 0; k < 7; k++) begin
         case (k)
            0: apply(0, 3'b111, 3'b000, 0, T_IDLE,   B_SINGLE, 1, 3'b001, 3'b000, 2'd0);
            1: apply(0, 3'b111, 3'b000, 0, T_NONSEQ, B_INCR8,  1, 3'b001, 3'b001, 2'd0);
            2: apply(0, 3'b111, 3'b000, 0, T_SEQ,    B_INCR8,  1, 3'b001, 3'b001, 2'd0);
            3: apply(1, 3'b111, 3'b000, 0, T_SEQ,    B_INCR8,  0, 3'b000, 3'b000, 2'd0);
            4: apply(0, 3'b101, 3'b000, 0, T_IDLE,   B_SINGLE, 1, 3'b001, 3'b000, 2'd0);
            5: apply(0, 3'b101, 3'b000, 0, T_NONSEQ, B_SINGLE, 1, 3'b001, 3'b001, 2'd0);
            6: apply(0, 3'b101, 3'b000, 0, T_NONSEQ, B_SINGLE, 1, 3'b100, 3'b001, 2'd2);
            default: ;
         endcase
         obs   = {hgrant, sel_addr, sel_data, hmaster_id};
         exp_w = sb.pop_front();
         n_checks++;
         if (obs !== exp_w) begin
            n_err++;
            $display("FAIL reset_mid step %0d: {grant,sel_addr,sel_data,id} got %b expected %b",
                     k, obs, exp_w);
         end
      end
   endtask

   // No requesters: port goes idle and the pointer is kept. A lone requester
   // is re-granted, and loses the port as soon as others request again.
   task automatic test_idle_regrant();
      reset_dut();
      for (int k = 0; k < 8; k++) begin
         case (k)
            0: apply(0, 3'b111, 3'b000, 0, T_IDLE,   B_SINGLE, 1, 3'b001, 3'b000, 2'd0);
            1: apply(0, 3'b000, 3'b000, 0, T_IDLE,   B_SINGLE, 1, 3'b000, 3'b001, 2'd0);
            2: apply(0, 3'b000, 3'b000, 0, T_IDLE,   B_SINGLE, 1, 3'b000, 3'b000, 2'd0);
            3: apply(0, 3'b101, 3'b000, 0, T_IDLE,   B_SINGLE, 1, 3'b100, 3'b000, 2'd2);
            4: apply(0, 3'b100, 3'b000, 2, T_NONSEQ, B_SINGLE, 1, 3'b100, 3'b100, 2'd2);
            5: apply(0, 3'b100, 3'b000, 2, T_NONSEQ, B_SINGLE, 1, 3'b100, 3'b100, 2'd2);
            6: apply(0, 3'b111, 3'b000, 2, T_NONSEQ, B_SINGLE, 1, 3'b100, 3'b100, 2'd2);
            7: apply(0, 3'b111, 3'b000, 2, T_NONSEQ, B_SINGLE, 1, 3'b001, 3'b100, 2'd0);
            default: ;
         endcase
         obs   = {hgrant, sel_addr, sel_data, hmaster_id};
         exp_w = sb.pop_front();
         n_checks++;
         if (obs !== exp_w) begin
            n_err++;
            $display("FAIL idle step %0d: {grant,sel_addr,sel_data,id} got %b expected %b",
                     k, obs, exp_w);
         end
      end
   endtask

   initial begin
      drive(1'b1, 3'b111, 3'b000, 0, T_IDLE, B_SINGLE, 1'b1);
      test_reset();
      test_rotation();
      test_incr4();
      test_wait_states();
      test_lock();
      test_reset_mid_burst();
      test_idle_regrant();
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
